// File: rtl/mini_i_cache_line.sv
// mini_i_cache_line: direct-mapped, read-only instruction cache with multi-word
// lines. A miss fetches the whole line in one burst from the bus, which takes one
// address handshake followed by LINE_WORDS data beats. flush invalidates every line.
// Optional feature macro: MINI_I_CACHE_PERF_EN adds saturating hit/miss counters.
//
//   state        | meaning
//   -------------+------------------------------------------------------------
//   IDLE         | ready for a fetch request
//   LOOKUP       | compare the latched address against the line tag and valid bit
//   REFILL_ADDR  | present the line base address to the bus
//   REFILL_DATA  | receive LINE_WORDS beats in offset order
//   RESP         | hold the instruction until the CPU takes it
module mini_i_cache_line #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  ir_addr_valid,
  output logic                  ir_addr_ready,
  input  logic [ADDR_WIDTH-1:0] ir_addr,
  output logic                  ir_data_valid,
  input  logic                  ir_data_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic                  bus_ir_addr_valid,
  input  logic                  bus_ir_addr_ready,
  output logic [ADDR_WIDTH-1:0] bus_ir_addr,
  input  logic                  bus_ir_data_valid,
  output logic                  bus_ir_data_ready,
  input  logic [DATA_WIDTH-1:0] bus_ir_data
`ifdef MINI_I_CACHE_PERF_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WORDS = NUM_LINES * LINE_WORDS;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_ADDR,
    REFILL_DATA,
    RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [OFF_W-1:0]        beat_q;
  logic                    flush_pend_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TAG_W-1:0]        tag_q [NUM_LINES];
  logic [DATA_WIDTH-1:0]   mem_q [WORDS];

  logic [TAG_W-1:0]        req_tag;
  logic [IDX_W-1:0]        req_idx;
  logic [OFF_W-1:0]        req_off;
  logic                    hit;
  logic                    accept;
  logic                    beat_fire;
  logic                    last_beat;
  logic                    resp_done;
  logic                    flush_all;

  assign req_tag = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];
  assign req_off = addr_q[OFF_W-1:0];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Handshake qualifiers and next-state selection
  always_comb begin
    state_d   = state_q;
    accept    = (state_q == IDLE) && ir_addr_valid;
    beat_fire = (state_q == REFILL_DATA) && bus_ir_data_valid;
    last_beat = beat_fire && (beat_q == LAST_BEAT);
    resp_done = (state_q == RESP) && ir_data_ready;
    // A flush seen outside IDLE waits until the response has gone, so the line just
    // refilled is dropped as well.
    flush_all = ((state_q == IDLE) && flush) || (resp_done && (flush || flush_pend_q));
    case (state_q)
      IDLE:        if (ir_addr_valid) state_d = LOOKUP;
      LOOKUP:      state_d = hit ? RESP : REFILL_ADDR;
      REFILL_ADDR: if (bus_ir_addr_ready) state_d = REFILL_DATA;
      REFILL_DATA: if (last_beat) state_d = RESP;
      RESP:        if (ir_data_ready) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // FSM state, beat counter, pending flush and valid bits (the resettable control)
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q <= state_d;
      if (beat_fire) beat_q <= beat_q + 1'b1;
      if (resp_done) flush_pend_q <= 1'b0;
      else if ((state_q != IDLE) && flush) flush_pend_q <= 1'b1;
      if (flush_all) valid_q <= '0;
      else if (last_beat) valid_q[req_idx] <= 1'b1;
    end
  end

  // Request address, response word, line data and tags (no reset; guarded by valid_q)
  always_ff @(posedge clock) begin
    if (accept) addr_q <= ir_addr;
    if ((state_q == LOOKUP) && hit) data_q <= mem_q[{req_idx, req_off}];
    if (beat_fire) begin
      mem_q[{req_idx, beat_q}] <= bus_ir_data;
      if (beat_q == req_off) data_q <= bus_ir_data;
    end
    if (last_beat) tag_q[req_idx] <= req_tag;
  end

  // Handshake outputs drop while reset is held so a reset mid-refill stops the bus at once
  assign ir_addr_ready     = (state_q == IDLE)        && !reset;
  assign ir_data_valid     = (state_q == RESP)        && !reset;
  assign bus_ir_addr_valid = (state_q == REFILL_ADDR) && !reset;
  assign bus_ir_data_ready = (state_q == REFILL_DATA) && !reset;
  assign ir_data           = data_q;
  assign bus_ir_addr       = {req_tag, req_idx, {OFF_W{1'b0}}};

`ifdef MINI_I_CACHE_PERF_EN
  logic [31:0] hit_q, miss_q;

  // Saturating lookup outcome counters; flush leaves them alone
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_q != '1) hit_q <= hit_q + 32'd1;
      end else begin
        if (miss_q != '1) miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_mini_i_cache_line.sv
// Bench for mini_i_cache_line (NUM_LINES=16, LINE_WORDS=4). The bench plays the part
// of the backing memory: word a holds a + 0x90. A small model records which line base
// sits in each index and predicts hit or miss. Build with MINI_I_CACHE_PERF_EN defined
// to check the counters as well.
module tb_mini_i_cache_line;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ir_addr_valid = 1'b0;
  logic        ir_data_ready = 1'b0;
  logic        bus_ir_addr_ready = 1'b0;
  logic        bus_ir_data_valid = 1'b0;
  logic [31:0] ir_addr = '0;
  logic [31:0] bus_ir_data = '0;
  logic        ir_addr_ready, ir_data_valid, bus_ir_addr_valid, bus_ir_data_ready;
  logic [31:0] ir_data, bus_ir_addr;
`ifdef MINI_I_CACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  bit          m_vld  [16];
  logic [31:0] m_base [16];
  int          m_hits = 0;
  int          m_miss = 0;

  typedef struct {
    logic [31:0] addr;
    bit          fb;
    bit          fs;
    bit          fm;
    int          astall;
    int          rstall;
    bit          hit;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [11];

  mini_i_cache_line dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .ir_addr_valid     (ir_addr_valid),
    .ir_addr_ready     (ir_addr_ready),
    .ir_addr           (ir_addr),
    .ir_data_valid     (ir_data_valid),
    .ir_data_ready     (ir_data_ready),
    .ir_data           (ir_data),
    .bus_ir_addr_valid (bus_ir_addr_valid),
    .bus_ir_addr_ready (bus_ir_addr_ready),
    .bus_ir_addr       (bus_ir_addr),
    .bus_ir_data_valid (bus_ir_data_valid),
    .bus_ir_data_ready (bus_ir_data_ready),
    .bus_ir_data       (bus_ir_data)
`ifdef MINI_I_CACHE_PERF_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a + 32'h90;
  endfunction

  function automatic bit model_hit(logic [31:0] a);
    return m_vld[a[5:2]] && (m_base[a[5:2]] == (a & ~32'h3));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    model_clear();
  endtask

  // One fetch, entered and left just after a falling edge. Acts as the bus and the CPU.
  task automatic fetch(input logic [31:0] a, input int astall, input int rstall,
                       input bit gaps, input bit flush_same, input int flush_beat,
                       output logic [31:0] data, output int hs, output int lat,
                       output logic [31:0] baddr, output bit held, output bit fired);
    int cyc, beat, acnt, rcnt;
    bit got_addr, done;
    logic [31:0] hold_data, base;
    hs = 0; lat = 0; held = 1'b1; fired = 1'b0; data = '0; baddr = '0;
    beat = 0; acnt = 0; rcnt = 0; got_addr = 1'b0; done = 1'b0; hold_data = '0;
    base = a & ~32'h3;
    cyc = 0;
    while (!ir_addr_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (!ir_addr_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    ir_addr_valid = 1'b1;
    ir_addr = a;
    flush = flush_same;
    @(negedge clock);
    ir_addr_valid = 1'b0;
    ir_addr = $urandom;
    flush = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      bus_ir_addr_ready = 1'b0;
      bus_ir_data_valid = 1'b0;
      ir_data_ready = 1'b0;
      flush = 1'b0;
      if (flush_beat >= 0 && !fired && bus_ir_data_ready && beat == flush_beat) begin
        flush = 1'b1;
        fired = 1'b1;
      end
      if (bus_ir_addr_valid) begin
        if (!got_addr) begin
          baddr = bus_ir_addr;
          got_addr = 1'b1;
        end else if (bus_ir_addr !== baddr) held = 1'b0;
        if (acnt >= astall) begin
          bus_ir_addr_ready = 1'b1;
          hs++;
        end else acnt++;
      end
      if (bus_ir_data_ready && !(gaps && $urandom_range(0, 2) == 0)) begin
        bus_ir_data_valid = 1'b1;
        bus_ir_data = mem_word(base + beat);
        beat++;
      end
      if (ir_data_valid) begin
        if (lat == 0) begin
          lat = cyc;
          hold_data = ir_data;
        end else if (ir_data !== hold_data) held = 1'b0;
        if (rcnt >= rstall) begin
          ir_data_ready = 1'b1;
          data = ir_data;
          done = 1'b1;
        end else rcnt++;
      end
      @(negedge clock);
      cyc++;
    end
    bus_ir_addr_ready = 1'b0;
    bus_ir_data_valid = 1'b0;
    ir_data_ready = 1'b0;
    flush = 1'b0;
    if (!done) check("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input logic [31:0] a, input bit fs, input bit fm,
                         input int astall, input int rstall, input bit gaps,
                         input bit exp_hit, input logic [31:0] exp_data, input string nm);
    logic [31:0] data, baddr;
    int hs, lat;
    bit held, fired;
    fetch(a, astall, rstall, gaps, fs, fm ? int'($urandom_range(0, 3)) : -1,
          data, hs, lat, baddr, held, fired);
    check({nm, "_data"}, data, exp_data);
    check({nm, "_bus_addr_handshakes"}, hs, exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) check({nm, "_bus_addr"}, baddr, a & ~32'h3);
    else check({nm, "_hit_latency"}, lat, 32'd2);
    if (astall > 0 || rstall > 0) check({nm, "_held_stable"}, {31'd0, held}, 32'd1);
    m_vld[a[5:2]] = 1'b1;
    m_base[a[5:2]] = a & ~32'h3;
    if (fired) model_clear();
    if (exp_hit) m_hits++;
    else m_miss++;
  endtask

  initial begin
    logic [31:0] a;
    bit fb, fs, fm, eh;
    int cyc, beats;

    vecs[0]  = '{32'h13,  0, 0, 0, 3, 0, 0, 32'hA3};
    vecs[1]  = '{32'h10,  0, 0, 0, 0, 5, 1, 32'hA0};
    vecs[2]  = '{32'h113, 0, 0, 0, 0, 0, 0, 32'h1A3};
    vecs[3]  = '{32'h13,  0, 0, 0, 0, 0, 0, 32'hA3};
    vecs[4]  = '{32'h12,  0, 0, 0, 1, 2, 1, 32'hA2};
    vecs[5]  = '{32'h10,  1, 0, 0, 0, 0, 0, 32'hA0};
    vecs[6]  = '{32'h11,  0, 0, 0, 0, 0, 1, 32'hA1};
    vecs[7]  = '{32'h11,  0, 1, 0, 0, 0, 0, 32'hA1};
    vecs[8]  = '{32'h23,  0, 0, 1, 0, 1, 0, 32'hB3};
    vecs[9]  = '{32'h20,  0, 0, 0, 0, 0, 0, 32'hB0};
    vecs[10] = '{32'h21,  0, 0, 0, 0, 0, 1, 32'hB1};
    model_clear();

    @(negedge clock);
    check("reset_ir_data_valid", {31'd0, ir_data_valid}, 32'd0);
    check("reset_bus_addr_valid", {31'd0, bus_ir_addr_valid}, 32'd0);
    check("reset_bus_data_ready", {31'd0, bus_ir_data_ready}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_reset_addr_ready", {31'd0, ir_addr_ready}, 32'd1);
    check("post_reset_ir_data_valid", {31'd0, ir_data_valid}, 32'd0);
    @(negedge clock);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].fb) pulse_flush();
      if (vecs[i].fs) model_clear();
      run_txn(vecs[i].addr, vecs[i].fs, vecs[i].fm, vecs[i].astall, vecs[i].rstall,
              i[0], vecs[i].hit, vecs[i].data, $sformatf("vec%0d", i));
`ifdef MINI_I_CACHE_PERF_EN
      if (i == 1) begin
        check("perf_hits_after_two", hit_count, 32'd1);
        check("perf_misses_after_two", miss_count, 32'd1);
      end
`endif
    end

    // Reset after two of four refill beats
    ir_addr_valid = 1'b1;
    ir_addr = 32'h10;
    @(negedge clock);
    ir_addr_valid = 1'b0;
    cyc = 0;
    while (!bus_ir_addr_valid && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    check("rst_seq_addr_request", {31'd0, bus_ir_addr_valid}, 32'd1);
    bus_ir_addr_ready = 1'b1;
    @(negedge clock);
    bus_ir_addr_ready = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats < 2 && cyc < 20) begin
      bus_ir_data_valid = 1'b0;
      if (bus_ir_data_ready) begin
        bus_ir_data_valid = 1'b1;
        bus_ir_data = mem_word(32'h10 + beats);
        beats++;
      end
      @(negedge clock);
      cyc++;
    end
    check("rst_seq_two_beats", beats, 32'd2);
    reset = 1'b1;
    bus_ir_data_valid = 1'b1;
    bus_ir_data = 32'hDEAD_BEEF;
    #1;
    check("rst_seq_data_ready_drops", {31'd0, bus_ir_data_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_seq_addr_ready_next", {31'd0, ir_addr_ready}, 32'd1);
    check("rst_seq_no_response", {31'd0, ir_data_valid}, 32'd0);
    @(negedge clock);
    bus_ir_data_valid = 1'b0;
    model_clear();
    m_hits = 0;
    m_miss = 0;
    run_txn(32'h10, 0, 0, 0, 0, 0, 0, 32'hA0, "after_reset_10");
    run_txn(32'h21, 0, 0, 0, 0, 0, 0, 32'hB1, "after_reset_21");

    // Randomized traffic over four tags and four indexes
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      fb = ($urandom_range(0, 7) == 0);
      fs = ($urandom_range(0, 9) == 0);
      if (fb) pulse_flush();
      if (fs) model_clear();
      eh = model_hit(a);
      fm = !eh && ($urandom_range(0, 5) == 0);
      run_txn(a, fs, fm, $urandom_range(0, 2), $urandom_range(0, 2), 1'b1, eh,
              mem_word(a), $sformatf("rnd%0d", i));
    end

`ifdef MINI_I_CACHE_PERF_EN
    check("perf_hits_final", hit_count, m_hits);
    check("perf_misses_final", miss_count, m_miss);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
